slice_stream: RTL and testbench

- Multi-channel, runtime-programmable bit-field extractor with valid/ready flow control.
- Each of NUM_CHANNELS lanes carries an INPUT_DATA_WIDTH word. Every lane is cut down to OUTPUT_DATA_WIDTH bits at a configurable offset, counted from the MSB or from the LSB.
- Offset and mode are reprogrammed at run time and take effect only on a frame boundary, marked by in_sync.
- Sits between ADC/FFT data paths and requantisation or packetisation stages. Replaces fixed compile-time slices.

---
 rtl/slice_stream_if.sv | 32 +++
 rtl/slice_stream.sv | 153 +++++++++++++++
 tb/tb_slice_stream.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/slice_stream_if.sv
// Stream and config bundle for slice_stream: packed lanes with valid/ready,
// frame sync, and the run-time offset/mode programming strobe.
interface slice_stream_if #(
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int OUTPUT_DATA_WIDTH = 8,
  parameter int NUM_CHANNELS      = 4,
  parameter int OFFSET_BITS       = 4
) ();
  logic [OFFSET_BITS-1:0]                    cfg_offset;
  logic                                      cfg_rel_to_msb;
  logic                                      cfg_load;
  logic                                      cfg_pending;
  logic                                      offset_err;
  logic                                      in_valid;
  logic                                      in_ready;
  logic                                      in_sync;
  logic [NUM_CHANNELS*INPUT_DATA_WIDTH-1:0]  data_in;
  logic                                      out_valid;
  logic                                      out_ready;
  logic                                      out_sync;
  logic [NUM_CHANNELS*OUTPUT_DATA_WIDTH-1:0] data_out;

  modport master (
    output cfg_offset, cfg_rel_to_msb, cfg_load, in_valid, in_sync, data_in, out_ready,
    input  cfg_pending, offset_err, in_ready, out_valid, out_sync, data_out
  );

  modport slave (
    input  cfg_offset, cfg_rel_to_msb, cfg_load, in_valid, in_sync, data_in, out_ready,
    output cfg_pending, offset_err, in_ready, out_valid, out_sync, data_out
  );
endinterface

// File: rtl/slice_stream.sv
// Multi-lane run-time programmable bit-field extractor with a one-entry skid
// buffer; offset/mode changes take effect only on an accepted sync beat.
module slice_stream #(
  parameter int INPUT_DATA_WIDTH   = 16,
  parameter int OUTPUT_DATA_WIDTH  = 8,
  parameter int NUM_CHANNELS       = 4,
  parameter int OFFSET_BITS        = 4,
  parameter int DEFAULT_OFFSET     = 0,
  parameter int DEFAULT_REL_TO_MSB = 1
) (
  input logic         clk,
  input logic         rst_n,
  slice_stream_if.slave bus
);
  localparam int IW      = INPUT_DATA_WIDTH;
  localparam int OW      = OUTPUT_DATA_WIDTH;
  localparam int MAX_OFF = IW - OW;
  localparam int SHW     = $clog2(IW + 1);
  localparam int DW      = NUM_CHANNELS * OW;

  logic [SHW-1:0]         active_off_q, active_off_d;
  logic                   active_msb_q, active_msb_d;
  logic [OFFSET_BITS-1:0] pend_off_q, pend_off_d;
  logic                   pend_msb_q, pend_msb_d;
  logic                   pend_q, pend_d;
  logic                   err_q, err_d;

  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_sync_q, out_sync_d;
  logic [DW-1:0]          out_data_q, out_data_d;
  logic                   skid_valid_q, skid_valid_d;
  logic                   skid_sync_q, skid_sync_d;
  logic [DW-1:0]          skid_data_q, skid_data_d;

  logic                   accept;
  logic                   apply;
  logic                   pend_illegal;
  logic [SHW-1:0]         pend_off_clamped;
  logic [SHW-1:0]         beat_off;
  logic                   beat_msb;
  logic [SHW-1:0]         shamt;
  logic [DW-1:0]          sliced;

  assign accept = bus.in_valid & in_ready_q;
  assign apply  = accept & bus.in_sync & pend_q;

  assign pend_illegal     = int'(pend_off_q) > MAX_OFF;
  assign pend_off_clamped = pend_illegal ? SHW'(MAX_OFF) : SHW'(pend_off_q);

  // The beat that activates a pending config is itself sliced with it.
  assign beat_off = apply ? pend_off_clamped : active_off_q;
  assign beat_msb = apply ? pend_msb_q : active_msb_q;
  assign shamt    = beat_msb ? (SHW'(MAX_OFF) - beat_off) : beat_off;

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
      assign sliced[gi*OW +: OW] = OW'(bus.data_in[gi*IW +: IW] >> shamt);
    end
  endgenerate

  always_comb begin
    active_off_d = active_off_q;
    active_msb_d = active_msb_q;
    err_d        = err_q;
    pend_off_d   = pend_off_q;
    pend_msb_d   = pend_msb_q;
    pend_d       = pend_q & ~apply;

    if (apply) begin
      active_off_d = pend_off_clamped;
      active_msb_d = pend_msb_q;
      err_d        = pend_illegal;
    end
    // A load coinciding with the applying beat stays pending for the next frame.
    if (bus.cfg_load) begin
      pend_off_d = bus.cfg_offset;
      pend_msb_d = bus.cfg_rel_to_msb;
      pend_d     = 1'b1;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_sync_d   = out_sync_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_sync_d  = skid_sync_q;
    skid_data_d  = skid_data_q;

    if (!out_valid_q || bus.out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_sync_d   = skid_sync_q;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_sync_d  = bus.in_sync;
        out_data_d  = sliced;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_sync_d  = bus.in_sync;
      skid_data_d  = sliced;
    end

    // in_ready is registered, so it must already be low in the cycle after the skid fills.
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_off_q <= SHW'(DEFAULT_OFFSET);
      active_msb_q <= (DEFAULT_REL_TO_MSB != 0);
      pend_off_q   <= '0;
      pend_msb_q   <= 1'b0;
      pend_q       <= 1'b0;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sync_q   <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_sync_q  <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      active_off_q <= active_off_d;
      active_msb_q <= active_msb_d;
      pend_off_q   <= pend_off_d;
      pend_msb_q   <= pend_msb_d;
      pend_q       <= pend_d;
      err_q        <= err_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_sync_q   <= out_sync_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_sync_q  <= skid_sync_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign bus.cfg_pending = pend_q;
  assign bus.offset_err  = err_q;
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sync    = out_sync_q;
  assign bus.data_out    = out_data_q;

endmodule

// File: tb/tb_slice_stream.sv
// Directed bench for slice_stream: reset, slicing modes, config timing,
// clamping, skid/stall ordering and asynchronous reset mid-stream.
module tb_slice_stream;
  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  localparam logic [63:0] D = 64'h1234_5678_9ABC_ABCD;

  slice_stream_if #(
    .INPUT_DATA_WIDTH(16), .OUTPUT_DATA_WIDTH(8), .NUM_CHANNELS(4), .OFFSET_BITS(4)
  ) bus ();

  slice_stream #(
    .INPUT_DATA_WIDTH(16), .OUTPUT_DATA_WIDTH(8), .NUM_CHANNELS(4), .OFFSET_BITS(4),
    .DEFAULT_OFFSET(0), .DEFAULT_REL_TO_MSB(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_step(input logic [3:0] off, input logic msb);
    bus.cfg_offset     = off;
    bus.cfg_rel_to_msb = msb;
    bus.cfg_load       = 1'b1;
    step();
    bus.cfg_load       = 1'b0;
  endtask

  task automatic beat_step(input logic s);
    bus.in_valid = 1'b1;
    bus.in_sync  = s;
    bus.data_in  = D;
    step();
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
  endtask

  // Stall scenario: beat number on lane MSBs, out_ready low for cycles 3-5.
  logic [7:0] st_beat [10] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4, 8'd4, 8'd5, 8'd6, 8'd0};
  logic       st_vld  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       st_ordy [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0] st_exp  [10] = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd0};
  logic       st_ov   [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       st_ir   [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n              = 1'b0;
    bus.cfg_offset     = '0;
    bus.cfg_rel_to_msb = 1'b0;
    bus.cfg_load       = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_sync        = 1'b0;
    bus.data_in        = '0;
    bus.out_ready      = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sync", bus.out_sync, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_cfg_pending", bus.cfg_pending, 0);
    chk("rst_offset_err", bus.offset_err, 0);
    #3 rst_n = 1'b1;
    step();
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_offset_err", bus.offset_err, 0);
    chk("idle_cfg_pending", bus.cfg_pending, 0);
    $display("reset/idle checked");

    beat_step(1'b0);
    chk("default_valid", bus.out_valid, 1);
    chk("default_data", bus.data_out, 32'h1256_9AAB);
    $display("default beat: data_out=%h", bus.data_out);
    step();
    chk("default_drain_valid", bus.out_valid, 0);

    load_step(4'd4, 1'b0);
    chk("lsb4_pending", bus.cfg_pending, 1);
    beat_step(1'b0);
    chk("lsb4_nosync_data", bus.data_out, 32'h1256_9AAB);
    chk("lsb4_nosync_pending", bus.cfg_pending, 1);
    beat_step(1'b1);
    chk("lsb4_sync_data", bus.data_out, 32'h2367_ABBC);
    chk("lsb4_sync_out_sync", bus.out_sync, 1);
    chk("lsb4_sync_pending", bus.cfg_pending, 0);
    $display("lsb offset 4 applied: data_out=%h", bus.data_out);

    load_step(4'd9, 1'b1);
    chk("clamp_err_before", bus.offset_err, 0);
    beat_step(1'b1);
    chk("clamp_data", bus.data_out, 32'h3478_BCCD);
    chk("clamp_err", bus.offset_err, 1);
    chk("clamp_pending", bus.cfg_pending, 0);
    beat_step(1'b0);
    chk("clamp_hold_data", bus.data_out, 32'h3478_BCCD);
    chk("clamp_hold_out_sync", bus.out_sync, 0);
    $display("msb offset 9 clamped: data_out=%h err=%0d", bus.data_out, bus.offset_err);

    load_step(4'd0, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b1;
    step();
    bus.in_sync  = 1'b0;
    chk("ignored_sync_pending", bus.cfg_pending, 1);
    chk("ignored_sync_err", bus.offset_err, 1);
    beat_step(1'b1);
    chk("legal_data", bus.data_out, 32'h1256_9AAB);
    chk("legal_err_clear", bus.offset_err, 0);
    $display("legal config restored: err=%0d", bus.offset_err);

    load_step(4'd4, 1'b0);
    bus.cfg_offset     = 4'd8;
    bus.cfg_rel_to_msb = 1'b1;
    bus.cfg_load       = 1'b1;
    beat_step(1'b1);
    bus.cfg_load       = 1'b0;
    chk("coincide_data", bus.data_out, 32'h2367_ABBC);
    chk("coincide_pending", bus.cfg_pending, 1);
    beat_step(1'b1);
    chk("coincide_next_data", bus.data_out, 32'h3478_BCCD);
    chk("coincide_next_err", bus.offset_err, 0);
    chk("coincide_next_pending", bus.cfg_pending, 0);
    $display("coincident load/sync: data_out=%h", bus.data_out);

    load_step(4'd0, 1'b1);
    beat_step(1'b1);
    chk("restore_data", bus.data_out, 32'h1256_9AAB);
    step();

    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = st_vld[i];
      bus.data_in   = {4{st_beat[i], 8'h00}};
      bus.out_ready = st_ordy[i];
      step();
      chk($sformatf("stream%0d_out_valid", i), bus.out_valid, st_ov[i]);
      chk($sformatf("stream%0d_in_ready", i), bus.in_ready, st_ir[i]);
      if (st_ov[i])
        chk($sformatf("stream%0d_data", i), bus.data_out, {4{st_exp[i]}});
      $display("stream step %0d: out_valid=%0d in_ready=%0d data_out=%h",
               i, bus.out_valid, bus.in_ready, bus.data_out);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    load_step(4'd15, 1'b1);
    beat_step(1'b1);
    chk("mid_clamp_data", bus.data_out, 32'h3478_BCCD);
    chk("mid_clamp_err", bus.offset_err, 1);
    load_step(4'd4, 1'b0);
    chk("mid_pending", bus.cfg_pending, 1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sync   = 1'b0;
    bus.data_in   = D;
    step();
    chk("mid_out_valid", bus.out_valid, 1);
    step();
    chk("mid_skid_full", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_out_sync", bus.out_sync, 0);
    chk("async_data_out", bus.data_out, 0);
    chk("async_in_ready", bus.in_ready, 0);
    chk("async_pending", bus.cfg_pending, 0);
    chk("async_err", bus.offset_err, 0);
    $display("async reset mid-stream checked");
    bus.out_ready = 1'b1;
    step();
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", bus.in_ready, 1);
    beat_step(1'b0);
    chk("post_rst_data", bus.data_out, 32'h1256_9AAB);
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_pending", bus.cfg_pending, 0);
    $display("post-reset default beat: data_out=%h", bus.data_out);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
